// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Brief    : Byte stream from the UART receiver with status flags.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling 8N1/8E1/8O1 UART receiver with valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int BAUD_RATE  = 115200,
    parameter int FREQUENCY  = 100000000,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd,
    uart_rx_if.master rx_if
);

    localparam int c_div = FREQUENCY / (BAUD_RATE * OVERSAMPLE) - 1;
    localparam int c_tw  = (c_div > 0) ? $clog2(c_div + 1) : 1;
    localparam int c_sw  = $clog2(OVERSAMPLE);
    localparam logic [c_tw-1:0] c_div_v  = c_tw'(c_div);
    localparam logic [c_sw-1:0] c_s_last = c_sw'(OVERSAMPLE - 1);
    localparam logic [c_sw-1:0] c_s_mid  = c_sw'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic [c_tw-1:0] r_tcnt;
    logic            w_tick;
    logic [1:0]      r_sync;
    logic            w_rxd_s;

    state_t          r_state, w_state_nxt;
    logic [c_sw-1:0] r_scnt, w_scnt_nxt;
    logic [2:0]      r_bcnt, w_bcnt_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_perr, w_perr_nxt;
    logic            w_commit;

    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_parity_err;
    logic            r_frame_err;
    logic            r_overrun;

    // Free-running oversample tick, independent of the receive FSM
    assign w_tick = (r_tcnt == c_div_v);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_tick) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + c_tw'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rxd};
        end
    end

    assign w_rxd_s = r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_scnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_shift <= w_shift_nxt;
            r_perr  <= w_perr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        w_perr_nxt  = r_perr;
        w_commit    = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxd_s) begin
                        w_state_nxt = S_START;
                        w_scnt_nxt  = '0;
                    end
                end
                S_START: begin
                    // Re-check the line at the start-bit centre to reject glitches
                    if (r_scnt == c_s_mid) begin
                        if (w_rxd_s) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_DATA;
                            w_scnt_nxt  = '0;
                            w_bcnt_nxt  = '0;
                        end
                    end else begin
                        w_scnt_nxt = r_scnt + c_sw'(1);
                    end
                end
                S_DATA: begin
                    if (r_scnt == c_s_last) begin
                        w_shift_nxt = {w_rxd_s, r_shift[7:1]};
                        w_scnt_nxt  = '0;
                        if (r_bcnt == 3'd7) begin
                            w_bcnt_nxt  = '0;
                            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            w_bcnt_nxt = r_bcnt + 3'd1;
                        end
                    end else begin
                        w_scnt_nxt = r_scnt + c_sw'(1);
                    end
                end
                S_PARITY: begin
                    if (r_scnt == c_s_last) begin
                        w_perr_nxt  = (PARITY == 1) ? (^r_shift ^ w_rxd_s)
                                                    : ~(^r_shift ^ w_rxd_s);
                        w_scnt_nxt  = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_scnt_nxt = r_scnt + c_sw'(1);
                    end
                end
                S_STOP: begin
                    if (r_scnt == c_s_last) begin
                        w_commit    = 1'b1;
                        w_scnt_nxt  = '0;
                        w_state_nxt = w_rxd_s ? S_IDLE : S_BREAK;
                    end else begin
                        w_scnt_nxt = r_scnt + c_sw'(1);
                    end
                end
                S_BREAK: begin
                    if (w_rxd_s) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // A commit always wins over a pending handshake; an unread byte is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_commit) begin
                r_data       <= r_shift;
                r_valid      <= 1'b1;
                r_parity_err <= r_perr;
                r_frame_err  <= ~w_rxd_s;
                r_overrun    <= r_valid & ~rx_if.rx_ready;
            end else if (r_valid && rx_if.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data    = r_data;
    assign rx_if.rx_valid   = r_valid;
    assign rx_if.parity_err = r_parity_err;
    assign rx_if.frame_err  = r_frame_err;
    assign rx_if.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx, one instance per parity mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_bit = 16;

    // {line[1:0], data[7:0], parity_err, frame_err}
    typedef logic [11:0] rec_t;

    typedef struct {
        int         ln;
        logic [7:0] b;
        logic       pbit;
        logic [7:0] ed;
        logic       epe;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd0 = 1'b1;
    logic rxd1 = 1'b1;
    logic rxd2 = 1'b1;

    int n_chk = 0;
    int n_err = 0;
    int ovr_cnt = 0;

    rec_t exp_q[$];
    rec_t got_q[$];

    uart_rx_if u_if0 ();
    uart_rx_if u_if1 ();
    uart_rx_if u_if2 ();

    uart_rx #(.BAUD_RATE(100), .FREQUENCY(1600), .OVERSAMPLE(8), .PARITY(0))
        u_dut0 (.clk(clk), .rst(rst), .rxd(rxd0), .rx_if(u_if0));
    uart_rx #(.BAUD_RATE(100), .FREQUENCY(1600), .OVERSAMPLE(8), .PARITY(1))
        u_dut1 (.clk(clk), .rst(rst), .rxd(rxd1), .rx_if(u_if1));
    uart_rx #(.BAUD_RATE(100), .FREQUENCY(1600), .OVERSAMPLE(8), .PARITY(2))
        u_dut2 (.clk(clk), .rst(rst), .rxd(rxd2), .rx_if(u_if2));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (u_if0.rx_valid && u_if0.rx_ready)
                got_q.push_back({2'd0, u_if0.rx_data, u_if0.parity_err, u_if0.frame_err});
            if (u_if1.rx_valid && u_if1.rx_ready)
                got_q.push_back({2'd1, u_if1.rx_data, u_if1.parity_err, u_if1.frame_err});
            if (u_if2.rx_valid && u_if2.rx_ready)
                got_q.push_back({2'd2, u_if2.rx_data, u_if2.parity_err, u_if2.frame_err});
            ovr_cnt <= ovr_cnt + int'(u_if0.overrun) + int'(u_if1.overrun) + int'(u_if2.overrun);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_line(input int ln, input logic v);
        case (ln)
            0:       rxd0 = v;
            1:       rxd1 = v;
            default: rxd2 = v;
        endcase
    endtask

    // Line 0 carries no parity bit; lines 1 and 2 do. A low stop bit leaves the line low.
    task automatic send_frame(input int ln, input logic [7:0] b, input logic pbit, input logic stop);
        set_line(ln, 1'b0);
        wait_clk(c_bit);
        for (int i = 0; i < 8; i++) begin
            set_line(ln, b[i]);
            wait_clk(c_bit);
        end
        if (ln != 0) begin
            set_line(ln, pbit);
            wait_clk(c_bit);
        end
        set_line(ln, stop);
        wait_clk(c_bit);
    endtask

    function automatic rec_t model(input int ln, input logic [7:0] b, input logic pbit, input logic stop);
        int   ones;
        logic pe;
        ones = $countones(b) + int'(pbit);
        if (ln == 1)      pe = (ones % 2) == 1;
        else if (ln == 2) pe = (ones % 2) == 0;
        else              pe = 1'b0;
        return {2'(ln), b, pe, ~stop};
    endfunction

    task automatic drain(input string nm);
        rec_t e, g;
        wait_clk(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                check({nm, "_missing"}, 32'(0), 32'(e));
            end else begin
                g = got_q.pop_front();
                check(nm, 32'(g), 32'(e));
            end
        end
        check({nm, "_extra"}, 32'(got_q.size()), 32'd0);
        while (got_q.size() > 0) void'(got_q.pop_front());
    endtask

    initial begin
        vec_t tbl[7];
        int   ovr_base;
        int   ln;
        logic [7:0] b;
        logic pbit, stop;

        tbl[0] = '{ln: 0, b: 8'hA5, pbit: 1'b0, ed: 8'hA5, epe: 1'b0};
        tbl[1] = '{ln: 0, b: 8'h00, pbit: 1'b0, ed: 8'h00, epe: 1'b0};
        tbl[2] = '{ln: 0, b: 8'hFF, pbit: 1'b0, ed: 8'hFF, epe: 1'b0};
        tbl[3] = '{ln: 1, b: 8'h03, pbit: 1'b1, ed: 8'h03, epe: 1'b1};
        tbl[4] = '{ln: 1, b: 8'h03, pbit: 1'b0, ed: 8'h03, epe: 1'b0};
        tbl[5] = '{ln: 2, b: 8'h03, pbit: 1'b1, ed: 8'h03, epe: 1'b0};
        tbl[6] = '{ln: 2, b: 8'h81, pbit: 1'b0, ed: 8'h81, epe: 1'b1};

        u_if0.rx_ready = 1'b1;
        u_if1.rx_ready = 1'b1;
        u_if2.rx_ready = 1'b1;

        wait_clk(3);
        check("reset_outputs",
              {19'd0, u_if0.rx_data, u_if0.rx_valid, u_if0.parity_err, u_if0.frame_err, u_if0.overrun},
              32'd0);
        rst = 1'b0;
        wait_clk(10);

        // Table vectors, sent back to back with no idle between frames
        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].ln, tbl[i].b, tbl[i].pbit, 1'b1);
            exp_q.push_back({2'(tbl[i].ln), tbl[i].ed, tbl[i].epe, 1'b0});
        end
        drain("table");

        // Glitch shorter than half a bit
        rxd0 = 1'b0;
        wait_clk(4);
        rxd0 = 1'b1;
        wait_clk(60);
        check("glitch_valid", 32'(u_if0.rx_valid), 32'd0);
        drain("glitch");

        // Framing error followed by a held-low break, then a normal byte
        send_frame(0, 8'h55, 1'b0, 1'b0);
        exp_q.push_back({2'd0, 8'h55, 1'b0, 1'b1});
        wait_clk(24);
        rxd0 = 1'b1;
        wait_clk(32);
        send_frame(0, 8'h12, 1'b0, 1'b1);
        exp_q.push_back({2'd0, 8'h12, 1'b0, 1'b0});
        drain("break");

        // Randomized frames against the reference model
        ovr_base = ovr_cnt;
        for (int i = 0; i < 30; i++) begin
            ln   = int'($urandom_range(0, 2));
            b    = 8'($urandom);
            pbit = 1'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(ln, b, pbit, stop);
            exp_q.push_back(model(ln, b, pbit, stop));
            set_line(ln, 1'b1);
            wait_clk(c_bit);
        end
        drain("random");
        check("random_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);

        // Overrun: consumer stalled across two commits
        u_if0.rx_ready = 1'b0;
        ovr_base = ovr_cnt;
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        wait_clk(40);
        check("overrun_pulses", 32'(ovr_cnt - ovr_base), 32'd1);
        check("overrun_valid", 32'(u_if0.rx_valid), 32'd1);
        check("overrun_data", 32'(u_if0.rx_data), 32'h22);
        drain("overrun");

        // Reset asserted in the middle of data bit 4
        rxd0 = 1'b0;
        wait_clk(c_bit);
        for (int i = 0; i < 8; i++) begin
            rxd0 = b[i] ^ 1'b1;
            if (i == 4) begin
                wait_clk(8);
                rst = 1'b1;
                wait_clk(2);
                check("midreset_valid", 32'(u_if0.rx_valid), 32'd0);
                check("midreset_outputs",
                      {19'd0, u_if0.rx_data, u_if0.rx_valid, u_if0.parity_err, u_if0.frame_err, u_if0.overrun},
                      32'd0);
                wait_clk(6);
            end else begin
                wait_clk(c_bit);
            end
        end
        rxd0 = 1'b1;
        wait_clk(c_bit + 4);
        rst = 1'b0;
        u_if0.rx_ready = 1'b1;
        wait_clk(20);
        send_frame(0, 8'h7E, 1'b0, 1'b1);
        exp_q.push_back({2'd0, 8'h7E, 1'b0, 1'b0});
        drain("after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive end of the serial link whose bit timing comes from the shared baud-rate settings (BAUD_RATE, FREQUENCY, 8x receive oversampling).
- Recovers 8N1 / 8E1 / 8O1 frames from the asynchronous rxd line and presents each byte on a valid/ready interface with parity, framing and overrun status.
- Runs entirely in the clk domain using a one-cycle oversample tick enable. No derived clocks are used.

Parameters:
- BAUD_RATE, 115200, line bit rate in bits/s.
- FREQUENCY, 100000000, clk frequency in Hz.
- OVERSAMPLE, 8, ticks per bit. Must be an even number, 4 or greater.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- rxd  input  1  serial input, idle high, asynchronous to clk.
- rx_data  output  8  received byte, LSB received first.
- rx_valid  output  1  rx_data and status flags valid.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- parity_err  output  1  parity mismatch on the held byte; always 0 when PARITY=0.
- frame_err  output  1  stop bit sampled low on the held byte.
- overrun  output  1  one-clk pulse: an unread byte was overwritten.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, state=IDLE, all counters 0, synchronizer flops=1.
- Tick generator:
  - DIV = FREQUENCY/(BAUD_RATE*OVERSAMPLE) - 1, integer division.
  - Counter counts 0..DIV. tick is high for 1 clk when counter==DIV, and the counter then wraps to 0.
  - Counter width is $clog2(DIV+1), minimum 1. Runs continuously and is never stopped by the FSM.
- Input sync: rxd passes through 2 flops (rxd_s). The FSM sees only rxd_s. All FSM actions below occur only on tick cycles.
- Counters: sample counter scnt (0..OVERSAMPLE-1); bit counter bcnt (0..7); 8-bit shift register.
- IDLE: when rxd_s==0 -> START, scnt=0.
- START:
  - scnt increments each tick.
  - At scnt==OVERSAMPLE/2-1 (bit centre), sample rxd_s.
  - If rxd_s==1: false start, return to IDLE.
  - If rxd_s==0: scnt=0, bcnt=0, -> DATA.
- DATA:
  - At scnt==OVERSAMPLE-1: sample rxd_s and shift it in from the MSB side, so the first bit received ends in rx_data[0]. Set scnt=0.
  - After bcnt==7 is sampled: go to PARITY if PARITY!=0, else STOP.
  - Otherwise increment scnt, and increment bcnt on each sample.
- PARITY:
  - At scnt==OVERSAMPLE-1, sample the parity bit. scnt=0, -> STOP.
  - perr = (XOR of data bits XOR parity bit) != 0 for even; == 0 for odd.
- STOP: at scnt==OVERSAMPLE-1, sample the stop bit and commit the frame.
  - Stop sampled 1: commit, then -> IDLE.
  - Stop sampled 0: commit with frame_err=1, then -> BREAK.
- Commit (registered, 1 clk after the stop-sample tick):
  - rx_data=shift register, rx_valid=1.
  - parity_err=perr, frame_err=(stop==0).
  - If rx_valid was 1 and not handshaken in the same cycle: overrun=1 for 1 clk, and the old byte is discarded.
- BREAK: wait for rxd_s==1 on a tick, then -> IDLE. This prevents a held-low line from retriggering.
- Handshake:
  - rx_valid && rx_ready clears rx_valid on the next clk. rx_data and the flags hold until the next commit.
  - Commit coincident with a handshake: the new byte loads, rx_valid stays 1, no overrun.
- rx_ready is ignored while rx_valid==0. The receiver never stalls the line; it only flags overrun.
- rst mid-frame: immediately returns to IDLE with reset values. The partial frame is lost. The next falling edge after rst deasserts starts a new frame.
- Latency: rx_valid rises 1 clk after the stop-centre tick. That is about 9.5 bit times (no parity) or 10.5 bit times (with parity) after the start edge, plus 2-3 clk of synchronizer and tick phase.

Test Plan:
All scenarios use FREQUENCY=1600, BAUD_RATE=100, OVERSAMPLE=8. This gives DIV=1, a tick every 2 clk, and 1 bit = 16 clk.
- Byte 0xA5, PARITY=0, rx_ready=1: shift 0xA5 LSB-first, stop=1 -> single rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, overrun=0.
- Back-to-back 0x00 then 0xFF with zero idle between frames, ready held 1 -> two commits with rx_data 0x00 then 0xFF, no errors.
- Glitch: rxd low for 4 clk (under half a bit), then high -> FSM returns to IDLE, rx_valid stays 0.
- PARITY=1 with 0x03, parity bit sent 1 -> parity_err=1, rx_data=0x03. Same byte with parity bit 0 -> parity_err=0. PARITY=2 with 0x03, parity bit 1 -> parity_err=0.
- Frame error and break: 0x55 with stop=0 and line held low for 40 clk -> rx_valid=1, rx_data=0x55, frame_err=1, no second frame. After rxd returns high, 0x12 is received normally.
- Overrun and reset: rx_ready=0, send 0x11 then 0x22 -> overrun pulse at the second commit, rx_data=0x22. Separately, assert rst during bit 4 of a frame -> all outputs 0. Release rst and send 0x7E -> rx_data=0x7E received correctly.
